// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// flags, registered read data with a valid strobe, and sticky overflow/underflow flags.
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  count;
  logic              rd_ok;
  logic              wr_ok;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Accesses in a reset cycle are ignored; a read at full frees the slot a write needs.
  always_comb begin
    rd_ok = i_rd_en & ~i_rst & (count != '0);
    wr_ok = i_wr_en & ~i_rst & ((count != DEPTH_C) | rd_ok);
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; stale contents
  // are never observable because reads are gated by count.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wp] <= i_wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values, matching the accept rules computed above.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= next_ptr(wp);
      if (rd_ok) begin
        rp        <= next_ptr(rp);
        o_rd_data <= mem[rp];
      end
      o_rd_valid <= rd_ok;

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A fresh error outranks a clear issued in the same cycle.
      if (i_wr_en & ~wr_ok)  o_overflow <= 1'b1;
      else if (i_err_clr)    o_overflow <= 1'b0;
      if (i_rd_en & ~rd_ok)  o_underflow <= 1'b1;
      else if (i_err_clr)    o_underflow <= 1'b0;
    end
  end

  assign o_count        = count;
  assign o_full         = (count == DEPTH_C);
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= AF_C);
  assign o_almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three instances (DEPTH 16, 5, 4) driven by directed steps; read
// data is checked by a scoreboard monitor, status outputs by direct comparisons.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] wr_en = '0, rd_en = '0, clr = '0;
  logic [7:0] wdata [3];
  logic [7:0] rdata [3];
  logic [2:0] rvalid, full, empty, af, ae, ovf, udf;
  logic [4:0] cnt16;
  logic [2:0] cnt5, cnt4;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  fifo_param #(.DATA_W(8), .DEPTH(16)) u16 (
    .i_clk(clk), .i_rst(rst[0]), .i_wr_en(wr_en[0]), .i_wr_data(wdata[0]),
    .i_rd_en(rd_en[0]), .i_err_clr(clr[0]), .o_rd_data(rdata[0]), .o_rd_valid(rvalid[0]),
    .o_full(full[0]), .o_empty(empty[0]), .o_almost_full(af[0]), .o_almost_empty(ae[0]),
    .o_count(cnt16), .o_overflow(ovf[0]), .o_underflow(udf[0]));

  fifo_param #(.DATA_W(8), .DEPTH(5)) u5 (
    .i_clk(clk), .i_rst(rst[1]), .i_wr_en(wr_en[1]), .i_wr_data(wdata[1]),
    .i_rd_en(rd_en[1]), .i_err_clr(clr[1]), .o_rd_data(rdata[1]), .o_rd_valid(rvalid[1]),
    .o_full(full[1]), .o_empty(empty[1]), .o_almost_full(af[1]), .o_almost_empty(ae[1]),
    .o_count(cnt5), .o_overflow(ovf[1]), .o_underflow(udf[1]));

  fifo_param #(.DATA_W(8), .DEPTH(4)) u4 (
    .i_clk(clk), .i_rst(rst[2]), .i_wr_en(wr_en[2]), .i_wr_data(wdata[2]),
    .i_rd_en(rd_en[2]), .i_err_clr(clr[2]), .o_rd_data(rdata[2]), .o_rd_valid(rvalid[2]),
    .o_full(full[2]), .o_empty(empty[2]), .o_almost_full(af[2]), .o_almost_empty(ae[2]),
    .o_count(cnt4), .o_overflow(ovf[2]), .o_underflow(udf[2]));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int d);
    case (d)
      0:       return int'(cnt16);
      1:       return int'(cnt5);
      default: return int'(cnt4);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic expect_rd(input int d, input logic [7:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rvalid[d]) begin
        if (qsize(d) == 0) check($sformatf("spurious_valid_dut%0d", d), 1, 0);
        else               check($sformatf("rd_data_dut%0d", d), int'(rdata[d]), int'(qpop(d)));
      end
    end
  end

  task automatic step(input int d, input bit w, input logic [7:0] wd, input bit r,
                      input bit c = 1'b0, input bit rs = 1'b0);
    wr_en[d] = w; wdata[d] = wd; rd_en[d] = r; clr[d] = c; rst[d] = rs;
    @(posedge clk); #1;
    wr_en = '0; rd_en = '0; clr = '0; rst = '0;
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check({tag, "_empty"}, int'(empty[d]), 1);
    check({tag, "_full"},  int'(full[d]),  0);
    check({tag, "_count"}, cnt(d),         0);
    check({tag, "_ae"},    int'(ae[d]),    1);
    check({tag, "_af"},    int'(af[d]),    0);
    check({tag, "_valid"}, int'(rvalid[d]), 0);
    check({tag, "_ovf"},   int'(ovf[d]),   0);
    check({tag, "_udf"},   int'(udf[d]),   0);
    check({tag, "_rdata"}, int'(rdata[d]), 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) wdata[d] = '0;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    check_reset_state(0, "rst16");
    check("rst5_count", cnt(1), 0);
    check("rst4_count", cnt(2), 0);

    // Single word through DEPTH=16
    step(0, 1, 8'h04, 0);
    check("t1_empty_after_wr", int'(empty[0]), 0);
    check("t1_count_after_wr", cnt(0), 1);
    expect_rd(0, 8'h04);
    step(0, 0, 8'h00, 1);
    check("t1_empty_after_rd", int'(empty[0]), 1);
    check("t1_count_after_rd", cnt(0), 0);
    step(0, 0, 8'h00, 0);

    // DEPTH=5: fill, overflow, drain, then wrap both pointers
    for (int i = 1; i <= 5; i++) step(1, 1, 8'(i), 0);
    check("t2_full", int'(full[1]), 1);
    check("t2_count_full", cnt(1), 5);
    check("t2_ovf_before", int'(ovf[1]), 0);
    step(1, 1, 8'h06, 0);
    check("t2_ovf_set", int'(ovf[1]), 1);
    check("t2_count_after_drop", cnt(1), 5);
    for (int i = 1; i <= 5; i++) begin
      expect_rd(1, 8'(i));
      step(1, 0, 8'h00, 1);
    end
    check("t2_empty_drained", int'(empty[1]), 1);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 8'(8'h20 + i), 0);
      expect_rd(1, 8'(8'h20 + i));
      step(1, 0, 8'h00, 1);
    end
    check("t2_count_after_wrap", cnt(1), 0);
    step(1, 0, 8'h00, 0, 1);
    check("t2_ovf_cleared", int'(ovf[1]), 0);

    // DEPTH=4: simultaneous read/write at full
    for (int i = 0; i < 4; i++) step(2, 1, 8'(8'h0A + i), 0);
    check("t3_full", int'(full[2]), 1);
    expect_rd(2, 8'h0A);
    step(2, 1, 8'h0E, 1);
    check("t3_count_stays", cnt(2), 4);
    check("t3_no_ovf", int'(ovf[2]), 0);
    for (int i = 0; i < 4; i++) begin
      expect_rd(2, 8'(8'h0B + i));
      step(2, 0, 8'h00, 1);
    end
    check("t3_empty", int'(empty[2]), 1);

    // Empty + simultaneous read/write: read rejected, write accepted, no bypass
    step(2, 1, 8'h55, 1);
    check("t4_udf_set", int'(udf[2]), 1);
    check("t4_count", cnt(2), 1);
    step(2, 0, 8'h00, 0, 1);
    check("t4_udf_cleared", int'(udf[2]), 0);
    expect_rd(2, 8'h55);
    step(2, 0, 8'h00, 1);
    check("t4_empty", int'(empty[2]), 1);
    step(2, 0, 8'h00, 1, 1);
    check("t4_err_beats_clr", int'(udf[2]), 1);
    step(2, 0, 8'h00, 0, 1);
    check("t4_udf_cleared2", int'(udf[2]), 0);

    // Thresholds on DEPTH=16 (AF=14, AE=2)
    step(0, 1, 8'h30, 0);
    step(0, 1, 8'h31, 0);
    check("t5_ae_at_2", int'(ae[0]), 1);
    step(0, 1, 8'h32, 0);
    check("t5_ae_at_3", int'(ae[0]), 0);
    for (int i = 3; i < 13; i++) step(0, 1, 8'(8'h30 + i), 0);
    check("t5_af_at_13", int'(af[0]), 0);
    step(0, 1, 8'h3D, 0);
    check("t5_count_14", cnt(0), 14);
    check("t5_af_at_14", int'(af[0]), 1);
    expect_rd(0, 8'h30);
    step(0, 0, 8'h00, 1);
    check("t5_af_back_13", int'(af[0]), 0);
    for (int i = 1; i <= 6; i++) begin
      expect_rd(0, 8'(8'h30 + i));
      step(0, 0, 8'h00, 1);
    end
    check("t6_count_7", cnt(0), 7);

    // Reset mid-operation with wr and rd active
    step(0, 1, 8'h77, 1, 0, 1);
    check_reset_state(0, "t6_rst");
    step(0, 0, 8'h00, 1);
    check("t6_udf_after_rst", int'(udf[0]), 1);
    check("t6_count_after_rst", cnt(0), 0);

    repeat (3) @(posedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("pending_reads_dut%0d", d), qsize(d), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock synchronous FIFO, successor to the fixed 16×8 buffer. It generalises data width and depth, and depth need not be a power of two. It adds occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, guarded (dropped) overflow/underflow accesses with sticky error flags, and defined simultaneous read/write behaviour at full and empty. It sits between producer and consumer logic in the same clock domain.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- AF_LEVEL, DEPTH-2, o_almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, o_almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- CNT_W, $clog2(DEPTH+1), width of o_count (derived, not overridden)

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_W  write data
- i_rd_en  in  1  read request
- i_err_clr  in  1  clears sticky error flags
- o_rd_data  out  DATA_W  read data, registered
- o_rd_valid  out  1  o_rd_data updated this cycle
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_almost_full  out  1  count ≥ AF_LEVEL
- o_almost_empty  out  1  count ≤ AE_LEVEL
- o_count  out  CNT_W  current occupancy
- o_overflow  out  1  sticky: write dropped because full
- o_underflow  out  1  sticky: read dropped because empty

## Operation
- Storage: DEPTH×DATA_W array; write pointer wp and read pointer rp in 0..DEPTH-1; count register 0..DEPTH. Full/empty come from count, not pointer MSB comparison.
- Pointer advance: ptr == DEPTH-1 → 0, else ptr+1. Wrap is explicit, so it works for non-power-of-two DEPTH.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = i_rd_en & (count != 0).
  - wr_ok = i_wr_en & ((count != DEPTH) | rd_ok). At full, a simultaneous read frees a slot and the write is accepted.
  - At empty, a simultaneous read is rejected. The write is accepted, and data is not bypassed.
- wr_ok: mem[wp] ← i_wr_data; wp advances.
- rd_ok: o_rd_data ← mem[rp]; rp advances; o_rd_valid = 1 next cycle.
- Count: +1 if wr_ok only, −1 if rd_ok only, unchanged if both or neither.
- Rejected write (i_wr_en & !wr_ok): data dropped, pointers and memory unchanged, o_overflow ← 1.
- Rejected read (i_rd_en & !rd_ok): o_rd_data holds, o_rd_valid = 0, o_underflow ← 1.
- Sticky flags: cleared by i_err_clr or i_rst. A new error in the same cycle as i_err_clr wins, and the flag stays 1.
- All status outputs are registered or decoded from registered count. Flags reflect post-edge count.

## Timing
- Reset values: wp = rp = count = 0, o_rd_data = 0, o_rd_valid = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = (AF_LEVEL == 0 ? 1 : 0), o_overflow = o_underflow = 0.
- Memory contents are not reset.
- Reset mid-operation: all of the above take effect at the reset edge. Any wr/rd in that cycle is ignored, and no error flag is set.
- Read latency: request at edge N → o_rd_data and o_rd_valid valid after edge N; o_rd_valid lasts one cycle per accepted read. Back-to-back reads give one word per cycle.
- Write-to-read: a word written at edge N clears o_empty after N and is readable by a request sampled at edge N+1.
- Flags and o_count update at the same edge as the accepting access; no extra cycle.
- Throughput: one write and one read per cycle sustained, including at full.

## Test plan
- DEPTH=16: reset, write 0x04, then read → o_rd_valid pulses once with 0x04; o_empty 1→0→1; o_count 0→1→0.
- DEPTH=5 (non-power-of-two): write 1..5 → o_full=1 and o_count=5. A 6th write of 0x06 is dropped and sets o_overflow=1. Five reads return 1,2,3,4,5. Writing and reading 7 more words wraps both pointers with data intact.
- Full + simultaneous rd/wr (DEPTH=4, filled with A..D, wr E with rd): read returns A, o_count stays 4, no overflow, and the next reads return B, C, D, E.
- Empty + simultaneous rd/wr: rd rejected and o_underflow=1, write of 0x55 accepted, o_count=1. i_err_clr clears o_underflow the next cycle, and the following read returns 0x55.
- Thresholds (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2): o_almost_empty drops when count goes from 2 to 3; o_almost_full rises at count 14 and falls back at 13.
- Reset asserted at count=7 with wr and rd active → all outputs at reset values next cycle, and a subsequent read reports underflow.
